// File: rtl/keypad_pkg.sv
// Shared types and constants for the memory-mapped 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} db_state_t;

    localparam int NEW_BIT  = 31;
    localparam int HELD_BIT = 4;
    localparam int CODE_LSB = 0;

    localparam logic [31:0] DEFAULT_KEY_ADDR = 32'h0000_FFF0;

    // Frame result: bit 4 set means no contact closed; otherwise bits 3:0 hold {col, row}.
    localparam logic [4:0] NO_KEY = 5'b1_0000;

    function automatic logic [1:0] lowest_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debounce FSM: turns one key-code result per frame into a stable press/release.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_done,
    input  logic [4:0] frame_code,
    output logic [3:0] key_code,
    output logic       held,
    output logic       accept
);

    localparam int CW = (DEBOUNCE_SCANS >= 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    db_state_t     state, state_next;
    logic [3:0]    cand, cand_next, code_next;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic          has_key;

    assign has_key = !frame_code[4];
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign held    = (state == HELD) || (state == REL_DB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cand     <= '0;
            cnt      <= '0;
            key_code <= '0;
        end else begin
            state    <= state_next;
            cand     <= cand_next;
            cnt      <= cnt_next;
            key_code <= code_next;
        end
    end

    // Evaluated only at frame end; a different code while pressing restarts from IDLE.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        code_next  = key_code;
        accept     = 1'b0;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (has_key) begin
                        cand_next = frame_code[3:0];
                        cnt_next  = CNT_ONE;
                        if (CNT_ONE >= CNT_MAX) begin
                            state_next = HELD;
                            code_next  = frame_code[3:0];
                            accept     = 1'b1;
                        end else begin
                            state_next = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (has_key && frame_code[3:0] == cand) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CNT_MAX) begin
                            state_next = HELD;
                            code_next  = cand;
                            accept     = 1'b1;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                HELD: begin
                    if (!has_key) begin
                        cnt_next   = CNT_ONE;
                        state_next = (CNT_ONE >= CNT_MAX) ? IDLE : REL_DB;
                    end
                end
                REL_DB: begin
                    if (!has_key) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= CNT_MAX) state_next = IDLE;
                    end else begin
                        state_next = HELD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Keypad scanner top: column drive, row synchronizer, frame resolution and the CPU-readable key register.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int          SCAN_DIV       = 50000,
    parameter int          DEBOUNCE_SCANS = 4,
    parameter logic [31:0] KEY_ADDR       = DEFAULT_KEY_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        memread,
    input  logic [31:0] dataadr,
    output logic [31:0] readdata,
    output logic        key_new
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_meta, row_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          last_dwell, row_hit, frame_done;
    logic          acc_valid;
    logic [3:0]    acc_code;
    logic [4:0]    frame_code;
    logic [3:0]    key_code;
    logic          held, accept, new_flag, read_hit;
    logic [31:0]   key_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign last_dwell = (dwell == DWELL_LAST);
    assign row_hit    = (row_sync != 4'hF);
    assign frame_done = last_dwell && (col_idx == 2'd3);
    assign col        = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
        end else if (last_dwell) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell   <= dwell + DW'(1);
        end
    end

    // Columns are visited lowest first, so the first hit latched in a frame is the lowest code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_valid <= 1'b0;
            acc_code  <= '0;
        end else if (last_dwell) begin
            if (col_idx == 2'd3) begin
                acc_valid <= 1'b0;
                acc_code  <= '0;
            end else if (!acc_valid && row_hit) begin
                acc_valid <= 1'b1;
                acc_code  <= {col_idx, lowest_row(row_sync)};
            end
        end
    end

    always_comb begin
        frame_code = NO_KEY;
        if (acc_valid)    frame_code = {1'b0, acc_code};
        else if (row_hit) frame_code = {1'b0, col_idx, lowest_row(row_sync)};
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_done (frame_done),
        .frame_code (frame_code),
        .key_code   (key_code),
        .held       (held),
        .accept     (accept)
    );

    assign read_hit = memread && (dataadr == KEY_ADDR);

    always_comb begin
        key_reg                  = '0;
        key_reg[NEW_BIT]         = new_flag;
        key_reg[HELD_BIT]        = held;
        key_reg[CODE_LSB +: 4]   = key_code;
    end

    // A press accepted on the same edge as a clearing read keeps the new flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            new_flag <= 1'b0;
            readdata <= '0;
        end else begin
            if (accept)        new_flag <= 1'b1;
            else if (read_hit) new_flag <= 1'b0;
            readdata <= read_hit ? key_reg : 32'h0;
        end
    end

    assign key_new = new_flag;

endmodule
